// File: rtl/snoop_bus_ctrl_if.sv
// Snoop bus bundle: the cache controllers are the master, the bus controller is the slave.
// Carries the request/grant, CDB broadcast, snoop ack/hit and completion signals.
interface snoop_bus_ctrl_if #(
   parameter int NUM_NODES = 4,
   parameter int MSG_W     = 22,
   parameter int SRC_W     = 2
);
   logic [NUM_NODES-1:0]       req_valid;
   logic [NUM_NODES*MSG_W-1:0] req_msg;
   logic [NUM_NODES-1:0]       req_grant;
   logic                       cdb_valid;
   logic [MSG_W-1:0]           cdb_msg;
   logic [SRC_W-1:0]           cdb_src;
   logic [NUM_NODES-1:0]       snoop_ack;
   logic [NUM_NODES-1:0]       snoop_hit;
   logic                       busy;
   logic                       done;
   logic                       done_hit;
   logic                       done_tmo;

   modport slave (
      input  req_valid, req_msg, snoop_ack, snoop_hit,
      output req_grant, cdb_valid, cdb_msg, cdb_src, busy, done, done_hit, done_tmo
   );

   modport master (
      output req_valid, req_msg, snoop_ack, snoop_hit,
      input  req_grant, cdb_valid, cdb_msg, cdb_src, busy, done, done_hit, done_tmo
   );
endinterface

// File: rtl/snoop_bus_ctrl.sv
// Snooping MSI bus controller: round-robin grant, 1-cycle CDB broadcast, then sticky snoop-ack collection.
// Grant 1 cycle after the request is seen; optional WAIT timeout enabled by defining SNOOP_TIMEOUT_EN.
module snoop_bus_ctrl #(
   parameter int NUM_NODES = 4,
   parameter int MSG_W     = 22,
   parameter int SRC_W     = 2,
   parameter int TIMEOUT   = 15
) (
   input  logic            clk_i,
   input  logic            rst_i,
   snoop_bus_ctrl_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_BCAST, S_WAIT} state_e;

   state_e               state_q, state_d;
   logic [SRC_W-1:0]     ptr_q, ptr_d;
   logic [SRC_W-1:0]     src_q, src_d;
   logic [MSG_W-1:0]     msg_q, msg_d;
   logic [NUM_NODES-1:0] ack_q, ack_d;
   logic [NUM_NODES-1:0] hit_q, hit_d;
   logic [NUM_NODES-1:0] grant_q, grant_d;
   logic                 cdb_valid_q, cdb_valid_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 done_hit_q, done_hit_d;

   logic [NUM_NODES-1:0] elig;
   logic [NUM_NODES-1:0] src_mask;
   logic [NUM_NODES-1:0] ack_new, hit_new;
   logic                 all_acked;
   logic                 tmo_hit;
   logic                 pick_vld;
   logic [SRC_W-1:0]     pick_idx;

`ifdef SNOOP_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_tmo_q, done_tmo_d;

   assign tmo_hit = (state_q == S_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1)) && !all_acked;
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT > 0);
   assign tmo_hit        = 1'b0;
`endif

   always_comb begin
      elig     = '0;
      src_mask = '0;
      for (int i = 0; i < NUM_NODES; i++) begin
         elig[i]     = bus.req_valid[i] && (bus.req_msg[i*MSG_W + MSG_W-2 +: 2] != 2'b00);
         src_mask[i] = (src_q == SRC_W'(i));
      end
   end

   // Scan from farthest to nearest so the node right after ptr wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int k = NUM_NODES; k >= 1; k--) begin
         for (int i = 0; i < NUM_NODES; i++) begin
            if (elig[i] && (i == (int'(ptr_q) + k) % NUM_NODES)) begin
               pick_vld = 1'b1;
               pick_idx = SRC_W'(i);
            end
         end
      end
   end

   // A hit only counts when it arrives with that node's first ack; src is never counted.
   assign ack_new   = ack_q | (bus.snoop_ack & ~src_mask);
   assign hit_new   = hit_q | (bus.snoop_hit & bus.snoop_ack & ~ack_q & ~src_mask);
   assign all_acked = &(ack_new | src_mask);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      src_d       = src_q;
      msg_d       = msg_q;
      ack_d       = ack_q;
      hit_d       = hit_q;
      grant_d     = '0;
      cdb_valid_d = 1'b0;
      done_d      = 1'b0;
      done_hit_d  = 1'b0;
`ifdef SNOOP_TIMEOUT_EN
      cnt_d       = cnt_q;
      done_tmo_d  = 1'b0;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               state_d     = S_BCAST;
               src_d       = pick_idx;
               cdb_valid_d = 1'b1;
               ack_d       = '0;
               hit_d       = '0;
               for (int i = 0; i < NUM_NODES; i++) begin
                  if (pick_idx == SRC_W'(i)) begin
                     grant_d[i] = 1'b1;
                     msg_d      = bus.req_msg[i*MSG_W +: MSG_W];
                  end
               end
            end
         end
         S_BCAST, S_WAIT: begin
            ack_d = ack_new;
            hit_d = hit_new;
            if (all_acked || tmo_hit) begin
               state_d    = S_IDLE;
               done_d     = 1'b1;
               done_hit_d = |hit_new;
               ptr_d      = src_q;
               ack_d      = '0;
               hit_d      = '0;
`ifdef SNOOP_TIMEOUT_EN
               done_tmo_d = tmo_hit;
`endif
            end else if (state_q == S_BCAST) begin
               state_d = S_WAIT;
`ifdef SNOOP_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end else begin
`ifdef SNOOP_TIMEOUT_EN
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         ptr_q       <= SRC_W'(NUM_NODES - 1);
         src_q       <= '0;
         msg_q       <= '0;
         ack_q       <= '0;
         hit_q       <= '0;
         grant_q     <= '0;
         cdb_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         done_hit_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         src_q       <= src_d;
         msg_q       <= msg_d;
         ack_q       <= ack_d;
         hit_q       <= hit_d;
         grant_q     <= grant_d;
         cdb_valid_q <= cdb_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         done_hit_q  <= done_hit_d;
      end
   end

`ifdef SNOOP_TIMEOUT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         done_tmo_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         done_tmo_q <= done_tmo_d;
      end
   end

   assign bus.done_tmo = done_tmo_q;
`else
   assign bus.done_tmo = 1'b0;
`endif

   assign bus.req_grant = grant_q;
   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_msg   = msg_q;
   assign bus.cdb_src   = src_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.done_hit  = done_hit_q;
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Directed bench for snoop_bus_ctrl: stimulus pushes expected broadcasts/completions (with their cycle)
// into a scoreboard; a negedge monitor pops and compares whenever grant/cdb_valid/done appears.
module tb_snoop_bus_ctrl;
   localparam int N = 4;
   localparam int W = 22;
   localparam int S = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      bit           is_done;
      logic [N-1:0] grant;
      logic [W-1:0] msg;
      logic [S-1:0] src;
      logic         hit;
      logic         tmo;
      int           at;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   snoop_bus_ctrl_if #(.NUM_NODES(N), .MSG_W(W), .SRC_W(S)) bus ();

   snoop_bus_ctrl #(.NUM_NODES(N), .MSG_W(W), .SRC_W(S), .TIMEOUT(15)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void exp_bc(input int node, input logic [W-1:0] m, input int at);
      exp_t e;
      e.is_done    = 1'b0;
      e.grant      = '0;
      e.grant[node] = 1'b1;
      e.msg        = m;
      e.src        = S'(node);
      e.hit        = 1'b0;
      e.tmo        = 1'b0;
      e.at         = at;
      sb.push_back(e);
   endfunction

   function automatic void exp_done(input logic hit, input logic tmo, input int at);
      exp_t e;
      e.is_done = 1'b1;
      e.grant   = '0;
      e.msg     = '0;
      e.src     = '0;
      e.hit     = hit;
      e.tmo     = tmo;
      e.at      = at;
      sb.push_back(e);
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (bus.cdb_valid || (bus.req_grant != '0) || bus.done)) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: cdb_valid=%b grant=%b done=%b at cycle %0d, nothing expected",
                     bus.cdb_valid, bus.req_grant, bus.done, cyc);
         end else begin
            e = sb.pop_front();
            if (e.is_done) begin
               chk("done_kind", {bus.done, bus.cdb_valid}, 2'b10);
               chk("done_hit", bus.done_hit, e.hit);
               chk("done_tmo", bus.done_tmo, e.tmo);
               chk("done_busy", bus.busy, 1'b0);
               chk("done_cycle", cyc, e.at);
            end else begin
               chk("bc_kind", {bus.done, bus.cdb_valid}, 2'b01);
               chk("bc_grant", bus.req_grant, e.grant);
               chk("bc_msg", bus.cdb_msg, e.msg);
               chk("bc_src", bus.cdb_src, e.src);
               chk("bc_busy", bus.busy, 1'b1);
               chk("bc_cycle", cyc, e.at);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_msg(input int node, input logic [W-1:0] m);
      bus.req_msg[node*W +: W] = m;
   endtask

   task automatic drain(input int budget);
      int b;
      b = budget;
      while (sb.size() != 0 && b > 0) begin
         tick(1);
         b--;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected outputs still pending after %0d cycles", sb.size(), budget);
         sb.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      bus.req_valid = '0;
      bus.req_msg   = '0;
      bus.snoop_ack = '0;
      bus.snoop_hit = '0;
      rst = 1'b1;
      tick(3);
      chk("reset_outputs", {bus.req_grant, bus.cdb_valid, bus.cdb_msg, bus.cdb_src,
                            bus.busy, bus.done, bus.done_hit, bus.done_tmo}, 64'd0);
      rst = 1'b0;
      tick(2);

      // Single request from node 2, acks from 0,1,3 during WAIT.
      t = cyc;
      set_msg(2, 22'h100ABC);
      bus.req_valid = 4'b0100;
      exp_bc(2, 22'h100ABC, t + 1);
      tick(1);
      bus.req_valid = '0;
      tick(1);
      chk("single_busy_wait", bus.busy, 1'b1);
      exp_done(1'b0, 1'b0, t + 3);
      bus.snoop_ack = 4'b1011;
      tick(1);
      bus.snoop_ack = '0;
      drain(10);
      chk("cdb_msg_hold", bus.cdb_msg, 22'h100ABC);
      chk("cdb_src_hold", bus.cdb_src, 2'd2);

      // Fastest completion (acks in BCAST) then back-to-back grant while done is high.
      t = cyc;
      set_msg(1, 22'h112345);
      bus.req_valid = 4'b0010;
      exp_bc(1, 22'h112345, t + 1);
      tick(1);
      bus.req_valid = '0;
      bus.snoop_ack = 4'b1101;
      exp_done(1'b0, 1'b0, t + 2);
      tick(1);
      bus.snoop_ack = '0;
      set_msg(3, 22'h300F0F);
      bus.req_valid = 4'b1000;
      exp_bc(3, 22'h300F0F, t + 3);
      tick(1);
      bus.req_valid = '0;
      bus.snoop_ack = 4'b0111;
      bus.snoop_hit = 4'b0100;
      exp_done(1'b1, 1'b0, t + 4);
      tick(1);
      bus.snoop_ack = '0;
      bus.snoop_hit = '0;
      drain(10);

      // Round robin: all nodes valid from reset, acks held high.
      rst = 1'b1;
      set_msg(0, 22'h100010);
      set_msg(1, 22'h200021);
      set_msg(2, 22'h300032);
      set_msg(3, 22'h100043);
      bus.req_valid = 4'b1111;
      bus.snoop_ack = 4'b1111;
      tick(2);
      t = cyc;
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         exp_bc(k % N, bus.req_msg[(k % N)*W +: W], t + 1 + 2*k);
         exp_done(1'b0, 1'b0, t + 2 + 2*k);
      end
      tick(9);
      bus.req_valid = '0;
      drain(10);
      bus.snoop_ack = '0;

      // Op filter: node 1 has op 00 and must never be granted.
      set_msg(1, 22'h00ABCD);
      set_msg(3, 22'h300F00);
      bus.snoop_ack = 4'b1111;
      t = cyc;
      bus.req_valid = 4'b1010;
      exp_bc(3, 22'h300F00, t + 1);
      exp_done(1'b0, 1'b0, t + 2);
      tick(1);
      bus.req_valid = 4'b0010;
      tick(12);
      chk("op00_idle", bus.busy, 1'b0);
      bus.req_valid = '0;
      bus.snoop_ack = '0;
      drain(2);

      // Hit from node 2 counts; src 0 ack/hit are masked and do not complete.
      set_msg(0, 22'h2ABCDE);
      t = cyc;
      bus.req_valid = 4'b0001;
      exp_bc(0, 22'h2ABCDE, t + 1);
      tick(1);
      bus.req_valid = '0;
      bus.snoop_ack = 4'b0001;
      bus.snoop_hit = 4'b0001;
      tick(1);
      bus.snoop_ack = 4'b0101;
      bus.snoop_hit = 4'b0101;
      tick(1);
      bus.snoop_ack = 4'b0001;
      bus.snoop_hit = 4'b0001;
      chk("mask_busy", bus.busy, 1'b1);
      tick(1);
      bus.snoop_ack = 4'b1011;
      bus.snoop_hit = 4'b0001;
      exp_done(1'b1, 1'b0, t + 5);
      tick(1);
      bus.snoop_ack = '0;
      bus.snoop_hit = '0;
      drain(10);

      // Src-only hit is ignored; a hit on a second ack is ignored.
      set_msg(1, 22'h100777);
      t = cyc;
      bus.req_valid = 4'b0010;
      exp_bc(1, 22'h100777, t + 1);
      tick(1);
      bus.req_valid = '0;
      bus.snoop_ack = 4'b0011;
      bus.snoop_hit = 4'b0010;
      tick(1);
      bus.snoop_ack = 4'b0001;
      bus.snoop_hit = 4'b0001;
      tick(1);
      bus.snoop_ack = 4'b1100;
      bus.snoop_hit = 4'b0000;
      exp_done(1'b0, 1'b0, t + 4);
      tick(1);
      bus.snoop_ack = '0;
      drain(10);

      // Reset mid-WAIT with 1 of 3 acks collected.
      set_msg(2, 22'h355555);
      t = cyc;
      bus.req_valid = 4'b0100;
      exp_bc(2, 22'h355555, t + 1);
      tick(1);
      bus.req_valid = '0;
      tick(1);
      bus.snoop_ack = 4'b0001;
      tick(1);
      bus.snoop_ack = '0;
      chk("pre_reset_busy", bus.busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_reset_outputs", {bus.req_grant, bus.cdb_valid, bus.cdb_msg, bus.cdb_src,
                                bus.busy, bus.done, bus.done_hit, bus.done_tmo}, 64'd0);
      tick(2);
      rst = 1'b0;
      tick(5);
      drain(1);
      set_msg(0, 22'h201010);
      set_msg(3, 22'h103030);
      bus.snoop_ack = 4'b1111;
      t = cyc;
      bus.req_valid = 4'b1001;
      exp_bc(0, 22'h201010, t + 1);
      exp_done(1'b0, 1'b0, t + 2);
      exp_bc(3, 22'h103030, t + 3);
      exp_done(1'b0, 1'b0, t + 4);
      tick(1);
      bus.req_valid = 4'b1000;
      tick(2);
      bus.req_valid = '0;
      drain(10);
      bus.snoop_ack = '0;

      // Node 3 never acks: timeout completion, or an unbounded WAIT when disabled.
      set_msg(1, 22'h20BEEF);
      t = cyc;
      bus.req_valid = 4'b0010;
      exp_bc(1, 22'h20BEEF, t + 1);
      tick(1);
      bus.req_valid = '0;
      bus.snoop_ack = 4'b0101;
      bus.snoop_hit = 4'b0001;
`ifdef SNOOP_TIMEOUT_EN
      exp_done(1'b1, 1'b1, t + 17);
      drain(30);
      chk("tmo_idle", bus.busy, 1'b0);
`else
      tick(40);
      chk("no_tmo_busy", bus.busy, 1'b1);
      chk("no_tmo_done_tmo", bus.done_tmo, 1'b0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
`endif
      bus.snoop_ack = '0;
      bus.snoop_hit = '0;
      tick(3);
      drain(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
